mem_a_read_seq: RTL and testbench

//  Read-side sequencer for the memory-to-memory transfer path. On Start it walks memory A from

---
 rtl/mem_xfer_pkg.sv | 24 ++
 rtl/mem_a_addr_ctr.sv | 45 ++++
 rtl/mem_a_read_seq.sv | 153 +++++++++++++++
 tb/tb_mem_a_read_seq.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_xfer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : mem_xfer_pkg                                                      |
// | Purpose  : Types and default widths shared by the memory-to-memory transfer  |
// |            path. This covers the A-side read sequencer, the B-side write     |
// |            counter and the memories.                                         |
// | Contents : DATA_W, ADDR_W default widths; state_t sequencer state encoding   |
// | Revision : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
package mem_xfer_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage : mem_xfer_pkg
`default_nettype wire

// File: rtl/mem_a_addr_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_a_addr_ctr                                                    |
// | Purpose  : Memory A address counter. It has a synchronous clear, an          |
// |            increment enable and a terminal-count flag that marks the last   |
// |            word of a transfer. Its structure mirrors the B-side counter.     |
// | Ports    : clk      - rising-edge clock                                      |
// |            rst_n    - asynchronous active-low reset                          |
// |            i_clr    - synchronous clear to 0 (wins over i_inc)               |
// |            i_inc    - increment by one                                       |
// |            o_count  - current address                                        |
// |            o_tc     - high when o_count == DEPTH-1                           |
// | Revision : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module mem_a_addr_ctr #(
  parameter int ADDR_W = mem_xfer_pkg::ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_count,
  output logic              o_tc
);

  localparam logic [ADDR_W-1:0] c_last = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + ADDR_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == c_last);

endmodule : mem_a_addr_ctr
`default_nettype wire

// File: rtl/mem_a_read_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_a_read_seq                                                    |
// | Purpose  : Read-side sequencer for the memory-to-memory transfer. On Start   |
// |            it reads memory A from address 0 to DEPTH-1 and presents each     |
// |            word on a valid/ready handshake to the B-side writer.             |
// | Ports    : clk, Reset_n (async active-low)                                   |
// |            Start, Abort        - control inputs                              |
// |            RdEnA, AddrA, DataA - memory A read port (1-cycle latency)        |
// |            DataOut, Valid, Ready - word stream to the B side                 |
// |            Busy, Done          - status (Done is a 1-cycle pulse)            |
// |            ParityOut           - even parity of DataOut (XFER_PARITY_EN)     |
// | Config   : XFER_PARITY_EN - adds the ParityOut output                        |
// | Revision : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module mem_a_read_seq #(
  parameter int DATA_W = mem_xfer_pkg::DATA_W,
  parameter int ADDR_W = mem_xfer_pkg::ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic              Abort,
  output logic              RdEnA,
  output logic [ADDR_W-1:0] AddrA,
  input  logic [DATA_W-1:0] DataA,
  output logic [DATA_W-1:0] DataOut,
  output logic              Valid,
  input  logic              Ready,
  output logic              Busy,
`ifdef XFER_PARITY_EN
  output logic [0:0]        ParityOut,
`endif
  output logic              Done
);

  import mem_xfer_pkg::*;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              w_clr;
  logic              w_inc;
  logic              w_tc;
  logic              w_hs;

  // A handshake only exists while a word is actually on offer.
  assign w_hs = r_valid && Ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and counter control
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_inc       = 1'b0;
    case (r_state)
      IDLE: begin
        if (Start) begin
          w_state_nxt = READ;
          w_clr       = 1'b1;
        end
      end
      READ: w_state_nxt = WAIT;
      WAIT: w_state_nxt = HOLD;
      HOLD: begin
        if (w_hs) begin
          if (w_tc) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = READ;
            w_inc       = 1'b1;
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    // Abort overrides everything, including a handshake in the same cycle and
    // a Start in IDLE. The address is left where it was.
    if (Abort) begin
      w_state_nxt = IDLE;
      w_clr       = 1'b0;
      w_inc       = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output word register: captured in WAIT, when memory A data has arrived.
  // Valid follows entry into / residence in HOLD, so it drops the cycle after
  // a handshake or an Abort.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (r_state == WAIT) begin
        r_data <= DataA;
      end
      r_valid <= (w_state_nxt == HOLD);
    end
  end

`ifdef XFER_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_parity <= 1'b0;
    end else if (r_state == WAIT) begin
      r_parity <= ^DataA;
    end
  end

  assign ParityOut = r_parity;
`endif

  mem_a_addr_ctr #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_addr_ctr (
    .clk     (clk),
    .rst_n   (Reset_n),
    .i_clr   (w_clr),
    .i_inc   (w_inc),
    .o_count (AddrA),
    .o_tc    (w_tc)
  );

  // Status strobes decode straight from the state register, so an
  // asynchronous reset clears them immediately.
  assign RdEnA   = (r_state == READ);
  assign Busy    = (r_state != IDLE);
  assign Done    = (r_state == DONE);
  assign DataOut = r_data;
  assign Valid   = r_valid;

endmodule : mem_a_read_seq
`default_nettype wire

// File: tb/tb_mem_a_read_seq.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : tb_mem_a_read_seq                                                 |
// | Purpose  : Self-checking bench for mem_a_read_seq. A behavioural memory A    |
// |            model serves reads. A transaction-level expectation (word order,  |
// |            cycle spacing, Done and Busy timing) checks every cycle.          |
// | Config   : XFER_PARITY_EN - also checks ParityOut                            |
// | Revision : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_mem_a_read_seq;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          Reset_n;
  logic          Start;
  logic          Abort;
  logic          Ready;
  logic          RdEnA;
  logic [AW-1:0] AddrA;
  logic [DW-1:0] DataA = '0;
  logic [DW-1:0] DataOut;
  logic          Valid;
  logic          Busy;
  logic          Done;
`ifdef XFER_PARITY_EN
  logic [0:0]    ParityOut;
`endif

  logic [DW-1:0] mem [DEPTH];

  int checks = 0;
  int errors = 0;

  mem_a_read_seq #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .Reset_n   (Reset_n),
    .Start     (Start),
    .Abort     (Abort),
    .RdEnA     (RdEnA),
    .AddrA     (AddrA),
    .DataA     (DataA),
    .DataOut   (DataOut),
    .Valid     (Valid),
    .Ready     (Ready),
    .Busy      (Busy),
`ifdef XFER_PARITY_EN
    .ParityOut (ParityOut),
`endif
    .Done      (Done)
  );

  always #5 clk = ~clk;

  // Memory A: synchronous read, data valid the cycle after RdEnA.
  always @(posedge clk) begin
    if (RdEnA) DataA <= mem[AddrA];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rden"},  RdEnA,   0);
    chk({tag, "_addr"},  AddrA,   0);
    chk({tag, "_data"},  DataOut, 0);
    chk({tag, "_valid"}, Valid,   0);
    chk({tag, "_busy"},  Busy,    0);
    chk({tag, "_done"},  Done,    0);
`ifdef XFER_PARITY_EN
    chk({tag, "_par"},   ParityOut, 0);
`endif
  endtask

  // One transfer. The expectation is phrased in transfer terms: after Start
  // or after each accepted word, the next word is on offer 3 cycles later.
  // Words appear in memory order, one address per word. Done follows the
  // last acceptance by one cycle. Optional stall, Abort and reset injection.
  task automatic run_xfer(input int rdy_pct, input int stall_beat, input int stall_n,
                          input int abort_beat, input int rst_beat);
    int beat;
    int since;
    int stalls;
    bit fin;
    beat = 0; since = 0; stalls = 0; fin = 0;
    Start = 1'b1; Abort = 1'b0; Ready = 1'b0;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      tick();
      since++;
      Start = 1'($urandom_range(1));          // must be ignored while busy
      if (beat == DEPTH) begin
        chk("done_pulse", Done, 1);
        chk("done_valid", Valid, 0);
        chk("done_busy", Busy, 1);
        Start = 1'b1;                          // Start during the Done cycle is ignored
        tick();
        Start = 1'b0;
        chk("post_done_busy", Busy, 0);
        chk("post_done_done", Done, 0);
        chk("idle_addr_hold", AddrA, DEPTH - 1);
        fin = 1;
      end else if (since < 3) begin
        chk("gap_valid", Valid, 0);
        chk("gap_busy", Busy, 1);
        chk("gap_done", Done, 0);
        chk("gap_rden", RdEnA, (since == 1));
        Ready = 1'($urandom_range(1));         // ignored while nothing is offered
        if (beat == rst_beat && since == 2) begin
          Reset_n = 1'b0;
          #1;
          chk_all_zero("async_rst");
          tick();
          Reset_n = 1'b1;
          Start   = 1'b0;
          Ready   = 1'b0;
          tick();
          chk("rst_stays_idle", Busy, 0);
          fin = 1;
        end
      end else begin
        chk("hold_valid", Valid, 1);
        chk("hold_rden", RdEnA, 0);
        chk("hold_done", Done, 0);
        chk("hold_data", DataOut, mem[beat]);
        chk("hold_addr", AddrA, beat);
`ifdef XFER_PARITY_EN
        chk("hold_parity", ParityOut, ^mem[beat]);
`endif
        if (beat == stall_beat && stalls < stall_n) begin
          Ready = 1'b0;
          stalls++;
        end else begin
          Ready = ($urandom_range(99) < rdy_pct);
        end
        if (beat == abort_beat) begin
          Ready = 1'b1;
          Abort = 1'b1;
          Start = 1'b0;
          tick();
          Abort = 1'b0;
          Ready = 1'b0;
          chk("abort_busy", Busy, 0);
          chk("abort_valid", Valid, 0);
          chk("abort_done", Done, 0);
          tick();
          chk("abort_no_done", Done, 0);
          chk("abort_still_idle", Busy, 0);
          fin = 1;
        end else if (Ready) begin
          beat++;
          since = 0;
        end
      end
    end
    Start = 1'b0;
    Ready = 1'b0;
    chk("xfer_finished", fin, 1);
  endtask

  initial begin
    // Reset with Start held high: nothing may start.
    Reset_n = 1'b0; Start = 1'b1; Abort = 1'b0; Ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    #1;
    chk_all_zero("reset");
    tick();
    tick();
    chk_all_zero("reset_held");
    Reset_n = 1'b1;
    Start   = 1'b0;
    tick();
    tick();
    chk_all_zero("post_reset");

    // Full transfer, Ready tied high.
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    run_xfer(100, -1, 0, -1, -1);

    // Backpressure: 5 stall cycles on word 8'h22.
    run_xfer(100, 1, 5, -1, -1);

    // Abort with the handshake of word 8'h33.
    run_xfer(100, -1, 0, 2, -1);

    // Reset in WAIT of word 1, then a clean restart from address 0.
    run_xfer(100, -1, 0, -1, 1);
    run_xfer(100, -1, 0, -1, -1);

    // Abort wins over Start in IDLE.
    Start = 1'b1; Abort = 1'b1;
    tick();
    Start = 1'b0; Abort = 1'b0;
    chk("abort_over_start_busy", Busy, 0);
    tick();
    chk("abort_over_start_rden", RdEnA, 0);

    // Randomised contents and Ready patterns.
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
      run_xfer(int'($urandom_range(100, 30)), int'($urandom_range(DEPTH - 1)),
               int'($urandom_range(4)), -1, -1);
    end

    // Parity pattern: 8'h07 has odd weight, 8'h03 even.
    mem[0] = 8'h07; mem[1] = 8'h03; mem[2] = 8'hFF; mem[3] = 8'h80;
    run_xfer(100, -1, 0, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mem_a_read_seq
`default_nettype wire
